// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the word-level serial pattern scanner.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    DONE = 2'b10
  } state_t;

  // Pattern loaded at reset when the pattern is 4 bits wide.
  localparam logic [3:0] DEF_PATTERN = 4'b1011;

  // Bits needed to hold any value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pat_det.sv
// Serial pattern detector: Mealy match flag over the last PAT_W bits,
// with optional non-overlapping match counting.
module pat_det #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             z
);

  localparam int                FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  win;

  // Oldest history bit lands in the window MSB, the live bit in the LSB.
  assign win = {hist, bit_in};
  assign z   = (fill == FILL_MAX) && (win == pattern);

  // History shift and fill tracking; a non-overlapping hit restarts the fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (en) begin
      hist <= win[PAT_W-2:0];
      if (z && !overlap)
        fill <= '0;
      else if (fill != FILL_MAX)
        fill <= fill + 1'b1;
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Accepts parallel words, scans them MSB-first through pat_det, and returns
// the match count and first-match index on a valid/ready result port.
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [CNT_W-1:0]  out_first,
  output logic              out_hit,
  output logic              busy
);

  localparam int               IDX_W    = cnt_width(WORD_W - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [PAT_W-1:0] PAT_RST  = (PAT_W == 4) ? PAT_W'(DEF_PATTERN) : {PAT_W{1'b1}};

  state_t            state_q, state_d;
  logic              load;
  logic              scanning;
  logic              z;
  logic [WORD_W-1:0] sreg;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  first;
  logic [PAT_W-1:0]  pat_q;
  logic              ovl_q;

  assign scanning  = (state_q == SCAN);
  assign busy      = (state_q != IDLE);
  assign out_count = count;
  assign out_first = first;
  assign out_hit   = (count != '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bit_idx == IDX_LAST) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Configuration is writable only while idle; later writes are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= PAT_RST;
      ovl_q <= 1'b1;
    end else if (state_q == IDLE && cfg_we) begin
      pat_q <= cfg_pattern;
      ovl_q <= cfg_overlap;
    end
  end

  // Word shift register feeding the detector MSB-first.
  always_ff @(posedge clk) begin
    if (load)          sreg <= in_data;
    else if (scanning) sreg <= {sreg[WORD_W-2:0], 1'b0};
  end

  // Scan index, match count and first-match index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
      count   <= '0;
      first   <= '0;
    end else if (load) begin
      bit_idx <= '0;
      count   <= '0;
      first   <= '0;
    end else if (scanning) begin
      bit_idx <= bit_idx + 1'b1;
      if (z) begin
        count <= count + 1'b1;
        if (count == '0) first <= CNT_W'(bit_idx);
      end
    end
  end

  pat_det #(
    .PAT_W (PAT_W)
  ) u_det (
    .clk     (clk),
    .rst     (rst),
    .clear   (load),
    .en      (scanning),
    .bit_in  (sreg[WORD_W-1]),
    .pattern (pat_q),
    .overlap (ovl_q),
    .z       (z)
  );

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Scoreboard bench for seq_scan_ctrl: directed cases plus randomized words.
module tb_seq_scan_ctrl;

  localparam int WORD_W = 16;
  localparam int PAT_W  = 4;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              cfg_overlap;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic [CNT_W-1:0]  out_first;
  logic              out_hit;
  logic              busy;

  typedef struct {
    int cnt;
    int first;
    int acc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_hs_edge = -100;
  logic [3:0] mpat = 4'b1011;
  bit         movl = 1'b1;
  bit         rdy_rand = 1'b0;
  bit         rdy_force = 1'b1;
  bit         prev_ov = 1'b0;

  seq_scan_ctrl #(.WORD_W(WORD_W), .PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_count   (out_count),
    .out_first   (out_first),
    .out_hit     (out_hit),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference: slide a PAT_W window over the scan order; non-overlapping
  // hits may not reuse any bit of the previous hit.
  function automatic void model(input logic [15:0] w, input logic [3:0] p, input bit ov,
                                output int cnt, output int first);
    int last_end;
    logic [15:0] sh;
    logic [3:0] win;
    cnt = 0; first = 0; last_end = -1;
    for (int i = PAT_W - 1; i < WORD_W; i++) begin
      sh  = w >> (WORD_W - 1 - i);
      win = sh[3:0];
      if (win == p && (ov || (i - PAT_W + 1) > last_end)) begin
        cnt++;
        if (cnt == 1) first = i;
        last_end = i;
      end
    end
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // Result port consumer handshake.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Monitor: latency on out_valid rise, fields on each handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (sb.size() == 0) check("unexpected_result", 1, 0);
          else check("latency", cyc - sb[0].acc, WORD_W);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_handshake", 1, 0);
          end else begin
            e = sb.pop_front();
            check("out_count", int'(out_count), e.cnt);
            check("out_first", int'(out_first), e.first);
            check("out_hit", int'(out_hit), (e.cnt != 0) ? 1 : 0);
          end
          last_hs_edge = cyc + 1;
        end
        prev_ov = out_valid;
      end
    end
  end

  // Offer a word (optionally with a same-cycle config write); called at a negedge.
  task automatic send_word(input logic [15:0] w, input bit push, input bit do_cfg,
                           input logic [3:0] p, input bit ov, output int acc);
    bit ok;
    exp_t e;
    in_valid = 1'b1; in_data = w;
    cfg_we = do_cfg; cfg_pattern = p; cfg_overlap = ov;
    ok = 1'b0; acc = -1;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (in_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      check("accept_timeout", 0, 1);
    end else begin
      acc = cyc + 1;
      if (do_cfg) begin mpat = p; movl = ov; end
      if (push) begin
        model(w, mpat, movl, e.cnt, e.first);
        e.acc = acc;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && sb.size() != 0; n++) @(negedge clk);
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int acc;
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset defaults.
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_out_count", int'(out_count), 0);
    check("rst_out_first", int'(out_first), 0);
    check("rst_out_hit", int'(out_hit), 0);

    // Default pattern on B0B0, then overlap on/off, then no-match.
    send_word(16'hB0B0, 1, 0, 4'h0, 0, acc);
    send_word(16'hAAAA, 1, 1, 4'b1010, 1, acc);
    send_word(16'hAAAA, 1, 1, 4'b1010, 0, acc);
    send_word(16'h0000, 1, 0, 4'h0, 0, acc);
    drain();

    // Backpressure with the next word already offered.
    rdy_force = 1'b0;
    send_word(16'hB0B0, 1, 1, 4'b1011, 1, acc);
    in_valid = 1'b1; in_data = 16'hB0B1;
    for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
    repeat (5) begin
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_in_ready", int'(in_ready), 0);
      check("bp_count_stable", int'(out_count), 2);
      check("bp_first_stable", int'(out_first), 3);
      @(negedge clk);
    end
    rdy_force = 1'b1;
    send_word(16'hB0B1, 1, 0, 4'h0, 0, acc);
    check("bp_accept_after_hs", acc, last_hs_edge + 1);
    drain();

    // Config write during SCAN is dropped.
    send_word(16'hB0B0, 1, 0, 4'h0, 0, acc);
    repeat (4) @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = 4'b0000; cfg_overlap = 1'b0;
    @(negedge clk);
    cfg_we = 1'b0;
    send_word(16'h0000, 1, 0, 4'h0, 0, acc);
    drain();

    // Reset mid-scan discards the word and restores the default config.
    send_word(16'hB0B0, 0, 1, 4'b0110, 0, acc);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    mpat = 4'b1011; movl = 1'b1;
    @(negedge clk);
    send_word(16'hB0B0, 1, 0, 4'h0, 0, acc);
    drain();

    // Randomized words, configs and consumer stalls.
    rdy_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [15:0] w;
      logic [3:0]  p;
      bit          dc, ov;
      w  = 16'($urandom);
      p  = 4'($urandom);
      ov = 1'($urandom_range(0, 1));
      dc = ($urandom_range(0, 2) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send_word(w, 1, dc, p, ov, acc);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
